// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline front end.
//   WORD_W            datapath width
//   DEFAULT_NOP_WORD  bubble instruction (sll $0,$0,0)
//   DEFAULT_RESET_PC  PC loaded on reset
//   fetchState_e      fetch-stage FSM encoding
package mips_pipe_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [WORD_W-1:0] DEFAULT_NOP_WORD = 32'h0000_0000;
    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        StBoot  = 2'd0,
        StFetch = 2'd1,
        StHold  = 2'd2
    } fetchState_e;

endpackage

// File: rtl/if_dec_reg.sv
// IF/DEC pipeline register.
//   clk       rising-edge clock
//   rst       asynchronous reset, active-low
//   load      capture instrIn/pc4In and mark valid
//   bubble    replace the instruction with NOP_WORD and clear valid (wins over load)
//   instrIn   instruction to capture
//   pc4In     PC+4 to capture
//   instr     registered instruction
//   pc4       registered PC+4
//   valid     register holds a real instruction
// With neither load nor bubble asserted the register holds.
module if_dec_reg
    import mips_pipe_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] instrIn,
    input  logic [31:0] pc4In,
    output logic [31:0] instr,
    output logic [31:0] pc4,
    output logic        valid
);

    logic [31:0] instrQ, instrD;
    logic [31:0] pc4Q, pc4D;
    logic        validQ, validD;

    always_comb begin
        instrD = instrQ;
        pc4D   = pc4Q;
        validD = validQ;
        if (bubble) begin
            // A bubble leaves PC+4 untouched; only the instruction is squashed.
            instrD = NOP_WORD;
            validD = 1'b0;
        end else if (load) begin
            instrD = instrIn;
            pc4D   = pc4In;
            validD = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instrQ <= NOP_WORD;
            pc4Q   <= 32'h0000_0000;
            validQ <= 1'b0;
        end else begin
            instrQ <= instrD;
            pc4Q   <= pc4D;
            validQ <= validD;
        end
    end

    assign instr = instrQ;
    assign pc4   = pc4Q;
    assign valid = validQ;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, instruction-memory handshake, one-entry skid
// buffer and the IF/DEC register.
//   Clk              rising-edge clock
//   Rst              asynchronous reset, active-low
//   Stall_DEC        decode asks IF/DEC to hold
//   Flush_EX         execute-stage redirect (highest priority)
//   Redirect_EX      redirect target, word aligned on use
//   ImemReq          fetch request valid
//   ImemAddr         fetch address (the PC)
//   ImemReady        ImemData valid for ImemAddr this cycle
//   ImemData         instruction word
//   PCResult         current PC
//   Instruction_DEC  IF/DEC instruction
//   PC4_DEC          IF/DEC PC+4
//   Valid_DEC        IF/DEC holds a real instruction
//   FetchCount       instructions delivered to decode (wraps)
module fetch_stage
    import mips_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall_DEC,
    input  logic        Flush_EX,
    input  logic [31:0] Redirect_EX,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemReady,
    input  logic [31:0] ImemData,
    output logic [31:0] PCResult,
    output logic [31:0] Instruction_DEC,
    output logic [31:0] PC4_DEC,
    output logic        Valid_DEC,
    output logic [31:0] FetchCount
);

    fetchState_e stateQ, stateD;
    logic [31:0] pcQ, pcD;
    logic [31:0] countQ, countD;
    logic        skidValidQ, skidValidD;
    logic [31:0] skidInstrQ, skidInstrD;
    logic [31:0] skidPc4Q, skidPc4D;

    logic        regLoad;
    logic        regBubble;
    logic [31:0] regInstr;
    logic [31:0] regPc4;
    logic [31:0] pcPlus4;

    assign pcPlus4 = pcQ + 32'd4;

    always_comb begin
        stateD     = stateQ;
        pcD        = pcQ;
        countD     = countQ;
        skidValidD = skidValidQ;
        skidInstrD = skidInstrQ;
        skidPc4D   = skidPc4Q;
        regLoad    = 1'b0;
        regBubble  = 1'b0;
        regInstr   = ImemData;
        regPc4     = pcPlus4;

        if (Flush_EX) begin
            // Any word returned this cycle belongs to the wrong path and is dropped.
            pcD        = Redirect_EX & ~32'd3;
            regBubble  = 1'b1;
            skidValidD = 1'b0;
            stateD     = StFetch;
        end else begin
            case (stateQ)
                StBoot: begin
                    stateD = StFetch;
                end
                StFetch: begin
                    if (ImemReady) begin
                        if (!Stall_DEC) begin
                            regLoad = 1'b1;
                            pcD     = pcPlus4;
                            countD  = countQ + 32'd1;
                        end else begin
                            // Decode can't take it: park the word, PC advances on release.
                            skidValidD = 1'b1;
                            skidInstrD = ImemData;
                            skidPc4D   = pcPlus4;
                            stateD     = StHold;
                        end
                    end else if (!Stall_DEC) begin
                        regBubble = 1'b1;
                    end
                end
                StHold: begin
                    if (!Stall_DEC) begin
                        if (skidValidQ) begin
                            regLoad  = 1'b1;
                            regInstr = skidInstrQ;
                            regPc4   = skidPc4Q;
                            pcD      = pcPlus4;
                            countD   = countQ + 32'd1;
                        end
                        skidValidD = 1'b0;
                        stateD     = StFetch;
                    end
                end
                default: begin
                    stateD = StBoot;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stateQ     <= StBoot;
            pcQ        <= RESET_PC;
            countQ     <= 32'h0000_0000;
            skidValidQ <= 1'b0;
            skidInstrQ <= NOP_WORD;
            skidPc4Q   <= 32'h0000_0000;
        end else begin
            stateQ     <= stateD;
            pcQ        <= pcD;
            countQ     <= countD;
            skidValidQ <= skidValidD;
            skidInstrQ <= skidInstrD;
            skidPc4Q   <= skidPc4D;
        end
    end

    if_dec_reg #(
        .NOP_WORD(NOP_WORD)
    ) u_if_dec_reg (
        .clk    (Clk),
        .rst    (Rst),
        .load   (regLoad),
        .bubble (regBubble),
        .instrIn(regInstr),
        .pc4In  (regPc4),
        .instr  (Instruction_DEC),
        .pc4    (PC4_DEC),
        .valid  (Valid_DEC)
    );

    // Request is a pure function of state, so it drops the moment reset hits.
    assign ImemReq    = (stateQ == StFetch);
    assign ImemAddr   = pcQ;
    assign PCResult   = pcQ;
    assign FetchCount = countQ;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] redirect;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic [31:0] imemData;
    logic [31:0] pcResult;
    logic [31:0] instrDec;
    logic [31:0] pc4Dec;
    logic        validDec;
    logic [31:0] fetchCount;

    int nCompared = 0;
    int nMismatched = 0;

    localparam logic [31:0] PAT = 32'hA5A5_0000;

    // Memory model: word at address A is A ^ PAT.
    assign imemData = imemAddr ^ PAT;

    fetch_stage dut (
        .Clk            (clk),
        .Rst            (rst),
        .Stall_DEC      (stall),
        .Flush_EX       (flush),
        .Redirect_EX    (redirect),
        .ImemReq        (imemReq),
        .ImemAddr       (imemAddr),
        .ImemReady      (imemReady),
        .ImemData       (imemData),
        .PCResult       (pcResult),
        .Instruction_DEC(instrDec),
        .PC4_DEC        (pc4Dec),
        .Valid_DEC      (validDec),
        .FetchCount     (fetchCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 32'h0; imemReady = 1'b1;
        repeat (2) @(negedge clk);
        nCompared++;
        if (pcResult !== 32'h0 || imemReq !== 1'b0 || validDec !== 1'b0 ||
            instrDec !== 32'h0 || pc4Dec !== 32'h0 || fetchCount !== 32'h0) begin
            nMismatched++;
            $display("FAIL reset_values: pc=%h req=%b v=%b instr=%h pc4=%h cnt=%0d required 0/0/0/0/0/0",
                     pcResult, imemReq, validDec, instrDec, pc4Dec, fetchCount);
        end
        #1 rst = 1'b1;
        nCompared++;
        if (imemReq !== 1'b0) begin
            nMismatched++;
            $display("FAIL boot_no_req: req=%b required 0", imemReq);
        end
        @(negedge clk);
        nCompared++;
        if (imemReq !== 1'b1 || imemAddr !== 32'h0 || validDec !== 1'b0) begin
            nMismatched++;
            $display("FAIL boot_to_fetch: req=%b addr=%h v=%b required 1/0/0",
                     imemReq, imemAddr, validDec);
        end
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 2; i++) begin
            logic [31:0] a;
            a = 32'(i - 1) * 4;
            @(negedge clk);
            nCompared++;
            if (pcResult !== a + 4 || instrDec !== (a ^ PAT) || pc4Dec !== a + 4 ||
                validDec !== 1'b1 || fetchCount !== 32'(i)) begin
                nMismatched++;
                $display("FAIL stream_%0d: pc=%h instr=%h pc4=%h v=%b cnt=%0d required %h/%h/%h/1/%0d",
                         i, pcResult, instrDec, pc4Dec, validDec, fetchCount,
                         a + 4, a ^ PAT, a + 4, i);
            end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nCompared++;
            if (imemReq !== 1'b0 || instrDec !== (32'h4 ^ PAT) || validDec !== 1'b1 ||
                pcResult !== 32'h8 || fetchCount !== 32'd2) begin
                nMismatched++;
                $display("FAIL stall_hold_%0d: req=%b instr=%h v=%b pc=%h cnt=%0d required 0/%h/1/8/2",
                         i, imemReq, instrDec, validDec, pcResult, fetchCount, 32'h4 ^ PAT);
            end
        end
        stall = 1'b0;
        @(negedge clk);
        nCompared++;
        if (instrDec !== (32'h8 ^ PAT) || pc4Dec !== 32'hC || pcResult !== 32'hC ||
            fetchCount !== 32'd3 || imemReq !== 1'b1) begin
            nMismatched++;
            $display("FAIL stall_release: instr=%h pc4=%h pc=%h cnt=%0d req=%b required %h/c/c/3/1",
                     instrDec, pc4Dec, pcResult, fetchCount, imemReq, 32'h8 ^ PAT);
        end
    endtask

    task automatic test_bubbles();
        imemReady = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            nCompared++;
            if (validDec !== 1'b0 || instrDec !== 32'h0 || imemAddr !== 32'hC ||
                pc4Dec !== 32'hC || imemReq !== 1'b1) begin
                nMismatched++;
                $display("FAIL bubble_%0d: v=%b instr=%h addr=%h pc4=%h req=%b required 0/0/c/c/1",
                         i, validDec, instrDec, imemAddr, pc4Dec, imemReq);
            end
        end
        imemReady = 1'b1;
        @(negedge clk);
        nCompared++;
        if (instrDec !== (32'hC ^ PAT) || pcResult !== 32'h10 || fetchCount !== 32'd4) begin
            nMismatched++;
            $display("FAIL after_bubble: instr=%h pc=%h cnt=%0d required %h/10/4",
                     instrDec, pcResult, fetchCount, 32'hC ^ PAT);
        end
    endtask

    task automatic test_flush();
        flush = 1'b1; redirect = 32'h0000_0043; stall = 1'b1;
        @(negedge clk);
        flush = 1'b0; stall = 1'b0;
        nCompared++;
        if (pcResult !== 32'h40 || validDec !== 1'b0 || instrDec !== 32'h0 ||
            fetchCount !== 32'd4 || imemReq !== 1'b1) begin
            nMismatched++;
            $display("FAIL flush: pc=%h v=%b instr=%h cnt=%0d req=%b required 40/0/0/4/1",
                     pcResult, validDec, instrDec, fetchCount, imemReq);
        end
        @(negedge clk);
        nCompared++;
        if (instrDec !== (32'h40 ^ PAT) || pc4Dec !== 32'h44 || fetchCount !== 32'd5) begin
            nMismatched++;
            $display("FAIL flush_refetch: instr=%h pc4=%h cnt=%0d required %h/44/5",
                     instrDec, pc4Dec, fetchCount, 32'h40 ^ PAT);
        end
    endtask

    task automatic test_wrap();
        flush = 1'b1; redirect = 32'hFFFF_FFFC;
        @(negedge clk);
        flush = 1'b0;
        nCompared++;
        if (pcResult !== 32'hFFFF_FFFC || fetchCount !== 32'd5) begin
            nMismatched++;
            $display("FAIL wrap_redirect: pc=%h cnt=%0d required fffffffc/5", pcResult, fetchCount);
        end
        @(negedge clk);
        nCompared++;
        if (pc4Dec !== 32'h0 || pcResult !== 32'h0 || instrDec !== 32'h5A5A_FFFC ||
            validDec !== 1'b1 || fetchCount !== 32'd6) begin
            nMismatched++;
            $display("FAIL wrap_accept: pc4=%h pc=%h instr=%h v=%b cnt=%0d required 0/0/5a5afffc/1/6",
                     pc4Dec, pcResult, instrDec, validDec, fetchCount);
        end
    endtask

    task automatic test_reset_in_hold();
        @(negedge clk);
        stall = 1'b1;
        @(negedge clk);
        nCompared++;
        if (imemReq !== 1'b0 || pcResult !== 32'h4 || fetchCount !== 32'd7 || validDec !== 1'b1) begin
            nMismatched++;
            $display("FAIL hold_entry: req=%b pc=%h cnt=%0d v=%b required 0/4/7/1",
                     imemReq, pcResult, fetchCount, validDec);
        end
        #2 rst = 1'b0;
        #1;
        nCompared++;
        if (pcResult !== 32'h0 || validDec !== 1'b0 || fetchCount !== 32'h0 ||
            imemReq !== 1'b0 || instrDec !== 32'h0 || pc4Dec !== 32'h0) begin
            nMismatched++;
            $display("FAIL async_reset: pc=%h v=%b cnt=%0d req=%b instr=%h pc4=%h required all 0",
                     pcResult, validDec, fetchCount, imemReq, instrDec, pc4Dec);
        end
        stall = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        nCompared++;
        if (instrDec !== PAT || validDec !== 1'b1 || fetchCount !== 32'd1) begin
            nMismatched++;
            $display("FAIL post_reset_fetch: instr=%h v=%b cnt=%0d required %h/1/1",
                     instrDec, validDec, fetchCount, PAT);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_bubbles();
        test_flush();
        test_wrap();
        test_reset_in_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
